pcie_link_status_led: RTL and testbench

Debounces the PCIe core's link-up flag, counts link drops, and turns link state into a readable LED pattern on the PCIe AXI clock. It sits directly downstream of the PCIe block design and consumes its raw link-up output. It replaces the direct wiring of link-up to the board LED with slow-blink / acknowledge-blink / steady-on signalling plus a drop counter for debug.

---
 rtl/pcie_link_status_led.sv | 95 +++++++++
 tb/tb_pcie_link_status_led.sv | 122 ++++++++++++
 2 files changed

// File: rtl/pcie_link_status_led.sv
// pcie_link_status_led: debounces PCIe link-up, counts link drops and drives a
// status LED (slow blink when down, three quick blinks on link-up, steady when up).
module pcie_link_status_led #(
    parameter int CLK_VALUE    = 100000000,
    parameter int DEBOUNCE_CYC = CLK_VALUE / 100,
    parameter int TICK_DIV     = CLK_VALUE / 10,
    parameter int CNT_W        = 16
) (
    input  logic             i_clk,
    input  logic             i_arst_n,
    input  logic             i_link_up,
    input  logic             i_clr_cnt,
    output logic             o_led,
    output logic             o_link_stable,
    output logic             o_link_drop,
    output logic [CNT_W-1:0] o_drop_cnt
);
    localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
    localparam int TK_W = $clog2(TICK_DIV);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [TK_W-1:0] TK_LAST = TK_W'(TICK_DIV - 1);
    localparam logic [1:0] S_DOWN = 2'd0;
    localparam logic [1:0] S_ACK  = 2'd1;
    localparam logic [1:0] S_UP   = 2'd2;

    logic [1:0]      r_sync;
    logic [DB_W-1:0] r_db_cnt;
    logic            r_stable_d;
    logic [TK_W-1:0] r_tick_cnt;
    logic [2:0]      r_blink;
    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic            w_tick;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_sync        <= '0;
            r_db_cnt      <= '0;
            r_stable_d    <= 1'b0;
            o_link_stable <= 1'b0;
            o_link_drop   <= 1'b0;
            o_drop_cnt    <= '0;
        end else begin
            r_sync      <= {r_sync[0], i_link_up};
            r_stable_d  <= o_link_stable;
            o_link_drop <= r_stable_d & ~o_link_stable;
            if (r_sync[1] == o_link_stable)
                r_db_cnt <= '0;
            else if (r_db_cnt == DB_LAST) begin
                o_link_stable <= r_sync[1];
                r_db_cnt      <= '0;
            end else
                r_db_cnt <= r_db_cnt + 1'b1;
            // a clear coinciding with a drop keeps that drop
            if (i_clr_cnt)
                o_drop_cnt <= CNT_W'(o_link_drop);
            else if (o_link_drop && !(&o_drop_cnt))
                o_drop_cnt <= o_drop_cnt + 1'b1;
        end
    end

    assign w_tick      = (r_tick_cnt == TK_LAST);
    assign w_state_nxt = !o_link_stable ? S_DOWN :
                         (r_state == S_DOWN) ? S_ACK :
                         (r_state == S_ACK && !(w_tick && r_blink == 3'd5)) ? S_ACK : S_UP;

    // tick phase restarts on every state change so each pattern begins cleanly
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_state    <= S_DOWN;
            r_tick_cnt <= '0;
            r_blink    <= '0;
            o_led      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) begin
                r_tick_cnt <= '0;
                r_blink    <= '0;
                o_led      <= (w_state_nxt != S_DOWN);
            end else if (!w_tick)
                r_tick_cnt <= r_tick_cnt + 1'b1;
            else begin
                r_tick_cnt <= '0;
                if (r_state == S_ACK) begin
                    r_blink <= r_blink + 1'b1;
                    o_led   <= r_blink[0];
                end else if (r_state == S_DOWN) begin
                    r_blink <= (r_blink == 3'd4) ? 3'd0 : r_blink + 1'b1;
                    o_led   <= (r_blink == 3'd4) ? ~o_led : o_led;
                end else
                    o_led <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pcie_link_status_led.sv
// tb_pcie_link_status_led: table-driven vectors with a due-cycle scoreboard,
// plus hand-written reset and asynchronous-reset sequences.
`timescale 1ns/100ps
module tb_pcie_link_status_led;
    typedef struct {
        logic       link;
        logic       clr;
        int         n;
        logic [4:0] exp;
    } vec_t;
    typedef struct {
        int         due;
        logic [4:0] exp;
        int         id;
    } sb_t;

    logic       clk     = 1'b0;
    logic       arst_n  = 1'b0;
    logic       link_up = 1'b0;
    logic       clr_cnt = 1'b0;
    logic       led, stable, drop;
    logic [1:0] cnt;
    logic [4:0] obs;
    int         cyc   = 0;
    int         n_vec = 0;
    int         n_bad = 0;
    int         split;
    vec_t       vecs[$];
    sb_t        sb[$];

    pcie_link_status_led #(.DEBOUNCE_CYC(4), .TICK_DIV(3), .CNT_W(2)) dut (
        .i_clk(clk), .i_arst_n(arst_n), .i_link_up(link_up), .i_clr_cnt(clr_cnt),
        .o_led(led), .o_link_stable(stable), .o_link_drop(drop), .o_drop_cnt(cnt)
    );

    assign obs = {led, stable, drop, cnt};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, int id, logic [4:0] got, logic [4:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s #%0d at cycle %0d: led/stable/drop/cnt got %b, expected %b",
                     name, id, cyc, got, exp);
        end
    endfunction

    function automatic void v(logic link, logic clr, int n, logic l, logic s, logic d, logic [1:0] c);
        vecs.push_back('{link, clr, n, {l, s, d, c}});
    endfunction

    task automatic run(int from, int upto);
        for (int i = from; i < upto; i++) begin
            link_up = vecs[i].link;
            clr_cnt = vecs[i].clr;
            sb.push_back('{cyc + vecs[i].n, vecs[i].exp, i});
            repeat (vecs[i].n) @(negedge clk);
        end
    endtask

    always @(negedge clk)
        for (int i = sb.size() - 1; i >= 0; i--)
            if (sb[i].due == cyc) begin
                chk("vec", sb[i].id, obs, sb[i].exp);
                sb.delete(i);
            end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        // down blink: toggles every 15 cycles
        v(0,0,14, 0,0,0,0); v(0,0,1, 1,0,0,0); v(0,0,14, 1,0,0,0); v(0,0,1, 0,0,0,0);
        v(0,0,10, 0,0,0,0);
        // link rise: stable on 6th edge, ACK pattern, then UP
        v(1,0,5, 1,0,0,0); v(1,0,1, 1,1,0,0); v(1,0,1, 1,1,0,0); v(1,0,3, 0,1,0,0);
        v(1,0,3, 1,1,0,0); v(1,0,3, 0,1,0,0); v(1,0,3, 1,1,0,0); v(1,0,3, 0,1,0,0);
        v(1,0,2, 0,1,0,0); v(1,0,1, 1,1,0,0); v(1,0,10, 1,1,0,0);
        // 3-cycle low glitch is filtered
        v(0,0,3, 1,1,0,0);
        for (int k = 0; k < 6; k++) v(1,0,1, 1,1,0,0);
        // first drop from UP
        v(0,0,6, 1,0,0,0); v(0,0,1, 0,0,1,0); v(0,0,1, 0,0,0,1);
        // drop during ACK, led mid-pattern
        v(1,0,7, 1,1,0,1); v(0,0,6, 1,0,0,1); v(0,0,1, 0,0,1,1); v(0,0,1, 0,0,0,2);
        // drops 3..5 saturate the counter
        v(1,0,7, 1,1,0,2); v(0,0,7, 0,0,1,2); v(0,0,1, 0,0,0,3);
        v(1,0,7, 1,1,0,3); v(0,0,7, 0,0,1,3); v(0,0,1, 0,0,0,3);
        v(1,0,7, 1,1,0,3); v(0,0,7, 0,0,1,3); v(0,0,1, 0,0,0,3);
        // clear alone, then a drop, then clear together with a drop
        v(0,1,1, 0,0,0,0); v(0,0,1, 0,0,0,0);
        v(1,0,7, 1,1,0,0); v(0,0,7, 0,0,1,0); v(0,0,1, 0,0,0,1);
        v(1,0,7, 1,1,0,1); v(0,0,7, 0,0,1,1); v(0,1,1, 0,0,0,1); v(0,0,1, 0,0,0,1);
        // back up to UP before the async reset
        v(1,0,7, 1,1,0,1); v(1,0,17, 0,1,0,1); v(1,0,1, 1,1,0,1); v(1,0,5, 1,1,0,1);
        split = vecs.size();
        // after async reset with link still up
        v(1,0,5, 0,0,0,0); v(1,0,1, 0,1,0,0); v(1,0,1, 1,1,0,0);

        repeat (2) @(negedge clk);
        chk("reset", -1, obs, 5'b0);
        arst_n = 1'b1;
        run(0, split);
        #2 arst_n = 1'b0;
        #0.5 chk("arst", -1, obs, 5'b0);
        #0.5 arst_n = 1'b1;
        run(split, vecs.size());
        for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d scoreboard entries pending, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
